// File: rtl/led_scheduler_if.sv
// Request/grant bundle between LED requesters and led_scheduler.
interface led_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] mode;
  logic [N_REQ-1:0]   grant;
  logic               busy;

  modport master (output req, output mode, input grant, input busy);
  modport slave  (input req, input mode, output grant, output busy);
endinterface

// File: rtl/led_scheduler.sv
// Round-robin time-sharing of one LED among N_REQ requesters with dwell limit and off-gap.
// Optional LED_PWM_EN dims every "on" value to 25% duty.
module led_scheduler #(
  parameter int N_REQ       = 4,
  parameter int CLK_HZ      = 100000000,
  parameter int TICK_HZ     = 1000,
  parameter int DWELL_TICKS = 500,
  parameter int GAP_TICKS   = 50,
  parameter int SLOW_HALF   = 250,
  parameter int FAST_HALF   = 50
) (
  input  logic             CLK100MHZ,
  input  logic             RST,
  led_scheduler_if.slave   bus,
  output logic             LED
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV - 1) + 1;
  localparam int DW  = $clog2(DWELL_TICKS) + 1;
  localparam int GW  = $clog2(GAP_TICKS) + 1;
  localparam int HMX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int HW  = $clog2(HMX) + 1;
  localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

  state_t           state_r, state_s;
  logic [PW-1:0]    pre_r;
  logic [IW-1:0]    ptr_r, ptr_s, owner_r, owner_s, pick_s;
  logic [N_REQ-1:0] grant_r, grant_s;
  logic [DW-1:0]    dwell_r, dwell_s;
  logic [GW-1:0]    gap_r, gap_s;
  logic [HW-1:0]    half_r, half_s, half_lim_s;
  logic             phase_r, phase_s;
  logic             led_r, led_s, busy_r, busy_s, on_s;
  logic [1:0]       owner_mode_s, pick_mode_s;
  logic             tick_s, owner_req_s, others_s, dwell_hit_s, gap_hit_s;
  logic             blink_s, toggle_s;

  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] pick;
    logic [IW-1:0] ci;
    logic          found;
    logic          hit;
    int            c;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      c     = (int'(p) + i >= N_REQ) ? int'(p) + i - N_REQ : int'(p) + i;
      ci    = IW'(c);
      hit   = !found && r[ci];
      pick  = hit ? ci : pick;
      found = found | hit;
    end
    return pick;
  endfunction

  function automatic logic [1:0] mode_of(input logic [2*N_REQ-1:0] m, input logic [IW-1:0] idx);
    logic [1:0] sel;
    sel = 2'b00;
    for (int i = 0; i < N_REQ; i++) begin
      sel = (idx == IW'(i)) ? m[2*i +: 2] : sel;
    end
    return sel;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [N_REQ-1:0] oh;
    for (int i = 0; i < N_REQ; i++) begin
      oh[i] = (idx == IW'(i));
    end
    return oh;
  endfunction

  function automatic logic led_val(input logic [1:0] md, input logic ph);
    logic v;
    case (md)
      2'b00:   v = 1'b0;
      2'b01:   v = 1'b1;
      2'b10:   v = ph;
      2'b11:   v = ph;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  assign tick_s       = (pre_r == PW'(DIV - 1));
  assign pick_s       = rr_pick(bus.req, ptr_r);
  assign pick_mode_s  = mode_of(bus.mode, pick_s);
  assign owner_mode_s = mode_of(bus.mode, owner_r);
  assign owner_req_s  = |(bus.req & grant_r);
  assign others_s     = |(bus.req & ~grant_r);
  assign dwell_hit_s  = tick_s && (dwell_r == DW'(DWELL_TICKS - 1));
  assign gap_hit_s    = tick_s && (gap_r == GW'(GAP_TICKS - 1));
  assign blink_s      = owner_mode_s[1];
  assign half_lim_s   = (owner_mode_s == 2'b11) ? HW'(FAST_HALF - 1) : HW'(SLOW_HALF - 1);
  // A mode switch from slow to fast can leave half_r above the new limit; >= fires at once.
  assign toggle_s     = tick_s && blink_s && (half_r >= half_lim_s);

`ifdef LED_PWM_EN
  logic [1:0] pwm_r;

  // Free-running dimming counter.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      pwm_r <= 2'd0;
    end else begin
      pwm_r <= pwm_r + 2'd1;
    end
  end

  assign on_s = (pwm_r == 2'd0);
`else
  assign on_s = 1'b1;
`endif

  // Next-state, counter and output decode.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    owner_s = owner_r;
    grant_s = grant_r;
    dwell_s = dwell_r;
    gap_s   = gap_r;
    half_s  = half_r;
    phase_s = phase_r;
    led_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          state_s = GRANT;
          owner_s = pick_s;
          grant_s = onehot(pick_s);
          dwell_s = {DW{1'b0}};
          half_s  = {HW{1'b0}};
          phase_s = 1'b1;
          led_s   = led_val(pick_mode_s, 1'b1);
        end else begin
          grant_s = {N_REQ{1'b0}};
        end
      end
      GRANT: begin
        if (!owner_req_s || (dwell_hit_s && others_s)) begin
          state_s = GAP;
          grant_s = {N_REQ{1'b0}};
          gap_s   = {GW{1'b0}};
          ptr_s   = (owner_r == IW'(N_REQ - 1)) ? {IW{1'b0}} : owner_r + IW'(1'b1);
        end else begin
          dwell_s = dwell_hit_s ? {DW{1'b0}} : dwell_r + DW'(tick_s);
          half_s  = toggle_s ? {HW{1'b0}} :
                    (tick_s && blink_s) ? half_r + HW'(1'b1) : half_r;
          phase_s = toggle_s ? ~phase_r : phase_r;
          led_s   = led_val(owner_mode_s, phase_s);
        end
      end
      GAP: begin
        grant_s = {N_REQ{1'b0}};
        if (gap_hit_s) begin
          state_s = IDLE;
        end else begin
          gap_s = gap_r + GW'(tick_s);
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = {N_REQ{1'b0}};
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state_r <= IDLE;
      pre_r   <= {PW{1'b0}};
      ptr_r   <= {IW{1'b0}};
      owner_r <= {IW{1'b0}};
      grant_r <= {N_REQ{1'b0}};
      dwell_r <= {DW{1'b0}};
      gap_r   <= {GW{1'b0}};
      half_r  <= {HW{1'b0}};
      phase_r <= 1'b1;
      led_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      pre_r   <= tick_s ? {PW{1'b0}} : pre_r + PW'(1'b1);
      ptr_r   <= ptr_s;
      owner_r <= owner_s;
      grant_r <= grant_s;
      dwell_r <= dwell_s;
      gap_r   <= gap_s;
      half_r  <= half_s;
      phase_r <= phase_s;
      led_r   <= led_s & on_s;
      busy_r  <= busy_s;
    end
  end

  assign LED       = led_r;
  assign bus.grant = grant_r;
  assign bus.busy  = busy_r;
endmodule

// File: doc/led_scheduler.md
Name: led_scheduler

Overview:
- Time-shares the board's single LED among N_REQ requesters using round-robin arbitration.
- Each owner holds the LED for a bounded dwell time, then the LED is forced off for a separation gap.
- Drives the LED in the owner's requested mode: off, solid, slow blink or fast blink.
- Sits between requesting logic and the top-level LED pin, clocked from CLK100MHZ.

Parameters:
N_REQ, 4, number of requesters (>=2)
CLK_HZ, 100000000, input clock frequency
TICK_HZ, 1000, internal tick rate; DIV = CLK_HZ/TICK_HZ, must be >=2
DWELL_TICKS, 500, maximum ticks one owner holds the LED while others wait
GAP_TICKS, 50, ticks LED is forced off between owners
SLOW_HALF, 250, slow-blink half period in ticks
FAST_HALF, 50, fast-blink half period in ticks

Ports:
CLK100MHZ  input  1  system clock; all logic on rising edge
RST  input  1  synchronous active-high reset
req  input  N_REQ  request per requester, level-sensitive
mode  input  2*N_REQ  per-requester mode; bits [2i+1:2i]: 00 off, 01 solid, 10 slow blink, 11 fast blink
LED  output  1  registered LED drive
grant  output  N_REQ  registered one-hot current owner; all zero when no owner
busy  output  1  high in GRANT or GAP

Behaviour:
- One clock domain. Reset is synchronous and active-high; clock port is CLK100MHZ, reset port is RST.
- Reset values: LED=0, grant=0, busy=0, state=IDLE, RR pointer=0, prescaler=0, all tick counters=0, blink phase=1. RST dominates every other event, including mid-grant.
- Prescaler: free-running count 0..DIV-1. tick pulses high for one cycle when count==DIV-1.
- A state's "K ticks" means expiry on the K-th tick pulse after entry. Counters clear on state entry.
- IDLE: LED=0, grant=0.
  - If any req is high, select the first requester at or after the pointer, searching upward with wrap.
  - Next cycle: GRANT, grant one-hot, dwell=0, blink phase=1. Request-to-grant latency is 1 cycle.
- GRANT:
  - LED = f(mode of owner), registered. 00 gives 0, 01 gives 1, 10/11 give the blink phase.
  - Blink phase toggles every SLOW_HALF (or FAST_HALF) ticks. The half-period counter clears on toggle.
  - A mode change takes effect next cycle without resetting the phase.
  - Dwell counter increments on tick.
  - Owner req low: GAP on the next cycle.
  - Dwell reaches DWELL_TICKS with another req pending: GAP.
  - Dwell reaches DWELL_TICKS with no other req pending: dwell clears and the owner keeps the LED.
  - Owner drop and dwell expiry in the same cycle: GAP.
  - On leaving GRANT, pointer = (owner+1) mod N_REQ.
- GAP: LED=0, grant=0, busy=1. After GAP_TICKS ticks, go to IDLE, which re-arbitrates; the new grant appears 1 cycle later.
- No combinational path from req/mode to LED or grant.
- Counter widths are $clog2 of their maximum value plus 1. No counter wraps before its terminal compare.

Optional Feature:
- Macro LED_PWM_EN.
- When defined:
  - A free-running 2-bit counter advances every clock.
  - Any "LED on" value is gated so the LED is high only when the counter==0, giving 25% duty for dimming.
  - Off values stay 0.
- When undefined: on = constant 1. The counter is not present.

Test Plan:
- Override params for all tests: CLK_HZ=1000, TICK_HZ=100 (DIV=10), DWELL_TICKS=4, GAP_TICKS=2, SLOW_HALF=3, FAST_HALF=1.
- Reset: assert RST 3 cycles with req=4'b1111 -> LED=0, grant=0, busy=0 throughout; first grant=4'b0001 exactly 1 cycle after the first clock edge with RST low.
- Solid: req=4'b0100, mode[5:4]=01 -> grant=4'b0100 and LED=1 one cycle after req is sampled; continues indefinitely because there is no contention.
- Round-robin: req=4'b1011 held, all modes solid -> grant sequence 0001, 0010, 1000, 0001; each grant ends on its 4th tick, followed by a 2-tick gap with LED=0.
- Blink: single owner, mode=10 -> LED toggles every 30 cycles (3 ticks); mode=11 -> toggles every 10 cycles.
- Drop/reset: owner drops req mid-grant -> grant=0 next cycle and GAP lasts 2 ticks; RST pulse mid-GRANT -> all outputs 0 next cycle and pointer=0.
- LED_PWM_EN defined, solid owner -> LED high exactly 1 of every 4 cycles.
